// File: rtl/dt_tree_walker.sv
// ---------------------------------------------------------------------------
// dt_tree_walker
//   Walks one decision tree stored in a node memory, starting at the root
//   (address 0). Each internal node names a feature and a Q32.32 threshold;
//   the walker fetches the feature, hands both to the external q32_comparator
//   and follows its go_left answer to the next node. A leaf node reports its
//   class in the low bits of the threshold field. A walk that visits
//   MAX_DEPTH internal nodes without reaching a leaf ends with err=1.
//
// Ports
//   clk, rst_n      clock and asynchronous active-low reset
//   start           begin a walk (sampled only while idle)
//   busy            walk in progress
//   done            one-cycle pulse, class_out/err valid
//   class_out       leaf class, held until the next walk finishes
//   err             depth limit reached (qualified by done)
//   node_addr       node memory address (synchronous, 1-cycle read)
//   node_rdata      {leaf, fidx, left, right, thr[63:0]}
//   feat_addr       feature memory address (synchronous, 1-cycle read)
//   feat_rdata      feature value, signed Q32.32
//   cmp_en          comparator enable
//   cmp_feature     comparator feature operand
//   cmp_threshold   comparator threshold operand
//   cmp_go_left     comparator result, feature <= threshold
//   cmp_done        comparator result valid (registered, 1 cycle after en)
// ---------------------------------------------------------------------------
module dt_tree_walker #(
  parameter int NODE_AW   = 8,
  parameter int FEAT_AW   = 4,
  parameter int CLASS_W   = 4,
  parameter int MAX_DEPTH = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  output logic                                busy,
  output logic                                done,
  output logic [CLASS_W-1:0]                  class_out,
  output logic                                err,
  output logic [NODE_AW-1:0]                  node_addr,
  input  logic [1+FEAT_AW+2*NODE_AW+64-1:0]   node_rdata,
  output logic [FEAT_AW-1:0]                  feat_addr,
  input  logic [63:0]                         feat_rdata,
  output logic                                cmp_en,
  output logic [63:0]                         cmp_feature,
  output logic [63:0]                         cmp_threshold,
  input  logic                                cmp_go_left,
  input  logic                                cmp_done
);

  localparam int NODE_W  = 1 + FEAT_AW + 2*NODE_AW + 64;
  localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    NODE_RD,
    NODE_LAT,
    FEAT_RD,
    FEAT_LAT,
    CMP,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [DEPTH_W-1:0]   depth_q, depth_d;
  logic [NODE_AW-1:0]   left_q, left_d;
  logic [NODE_AW-1:0]   right_q, right_d;
  logic [63:0]          thr_q, thr_d;
  logic                 cmp_first_q, cmp_first_d;

  logic                 busy_d, done_d, err_d, cmp_en_d;
  logic [CLASS_W-1:0]   class_out_d;
  logic [NODE_AW-1:0]   node_addr_d;
  logic [FEAT_AW-1:0]   feat_addr_d;
  logic [63:0]          cmp_feature_d, cmp_threshold_d;

  // Node word fields, meaningful only in NODE_LAT when the read data is valid.
  logic                 node_leaf;
  logic [FEAT_AW-1:0]   node_fidx;
  logic [NODE_AW-1:0]   node_left;
  logic [NODE_AW-1:0]   node_right;
  logic [63:0]          node_thr;

  assign node_leaf  = node_rdata[NODE_W-1];
  assign node_fidx  = node_rdata[NODE_W-2 -: FEAT_AW];
  assign node_left  = node_rdata[64+2*NODE_AW-1 -: NODE_AW];
  assign node_right = node_rdata[64+NODE_AW-1 -: NODE_AW];
  assign node_thr   = node_rdata[63:0];

  // All state and outputs are registered; this block holds the flops only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      depth_q       <= '0;
      left_q        <= '0;
      right_q       <= '0;
      thr_q         <= '0;
      cmp_first_q   <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      cmp_en        <= 1'b0;
      class_out     <= '0;
      node_addr     <= '0;
      feat_addr     <= '0;
      cmp_feature   <= '0;
      cmp_threshold <= '0;
    end else begin
      state_q       <= state_d;
      depth_q       <= depth_d;
      left_q        <= left_d;
      right_q       <= right_d;
      thr_q         <= thr_d;
      cmp_first_q   <= cmp_first_d;
      busy          <= busy_d;
      done          <= done_d;
      err           <= err_d;
      cmp_en        <= cmp_en_d;
      class_out     <= class_out_d;
      node_addr     <= node_addr_d;
      feat_addr     <= feat_addr_d;
      cmp_feature   <= cmp_feature_d;
      cmp_threshold <= cmp_threshold_d;
    end
  end

  // Next-state logic. Memory addresses are loaded on the edge that enters the
  // corresponding *_RD state so the synchronous memory sees them during that
  // state and returns data in the following *_LAT state.
  always_comb begin
    state_d         = state_q;
    depth_d         = depth_q;
    left_d          = left_q;
    right_d         = right_q;
    thr_d           = thr_q;
    cmp_first_d     = cmp_first_q;
    busy_d          = busy;
    done_d          = 1'b0;
    err_d           = err;
    cmp_en_d        = cmp_en;
    class_out_d     = class_out;
    node_addr_d     = node_addr;
    feat_addr_d     = feat_addr;
    cmp_feature_d   = cmp_feature;
    cmp_threshold_d = cmp_threshold;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          node_addr_d = '0;
          depth_d     = '0;
          err_d       = 1'b0;
          busy_d      = 1'b1;
          state_d     = NODE_RD;
        end
      end

      NODE_RD: begin
        state_d = NODE_LAT;
      end

      NODE_LAT: begin
        left_d  = node_left;
        right_d = node_right;
        thr_d   = node_thr;
        if (node_leaf) begin
          class_out_d = node_thr[CLASS_W-1:0];
          err_d       = 1'b0;
          done_d      = 1'b1;
          state_d     = DONE;
        end else if (depth_q == DEPTH_W'(MAX_DEPTH)) begin
          class_out_d = '0;
          err_d       = 1'b1;
          done_d      = 1'b1;
          state_d     = DONE;
        end else begin
          feat_addr_d = node_fidx;
          state_d     = FEAT_RD;
        end
      end

      FEAT_RD: begin
        state_d = FEAT_LAT;
      end

      FEAT_LAT: begin
        cmp_feature_d   = feat_rdata;
        cmp_threshold_d = thr_q;
        cmp_en_d        = 1'b1;
        cmp_first_d     = 1'b1;
        state_d         = CMP;
      end

      // The first CMP cycle may still see a done left over from an earlier
      // request, so cmp_done is only trusted from the second cycle on.
      CMP: begin
        cmp_first_d = 1'b0;
        if (!cmp_first_q && cmp_done) begin
          node_addr_d = cmp_go_left ? left_q : right_q;
          depth_d     = depth_q + DEPTH_W'(1);
          cmp_en_d    = 1'b0;
          state_d     = NODE_RD;
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dt_tree_walker.sv
// ---------------------------------------------------------------------------
// tb_dt_tree_walker
//   Self-checking bench for dt_tree_walker. Provides synchronous node and
//   feature memories and a registered q32_comparator model. Each walk pushes
//   its expected class, err and completion cycle to a scoreboard queue; the
//   entry is popped and compared when done pulses.
// ---------------------------------------------------------------------------
module tb_dt_tree_walker;

  localparam int NODE_AW = 8;
  localparam int FEAT_AW = 4;
  localparam int CLASS_W = 4;
  localparam int NODE_W  = 1 + FEAT_AW + 2*NODE_AW + 64;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic                busy, done, err;
  logic [CLASS_W-1:0]  class_out;
  logic [NODE_AW-1:0]  node_addr;
  logic [NODE_W-1:0]   node_rdata;
  logic [FEAT_AW-1:0]  feat_addr;
  logic [63:0]         feat_rdata;
  logic                cmp_en;
  logic [63:0]         cmp_feature, cmp_threshold;
  logic                cmp_go_left, cmp_done;

  logic [NODE_W-1:0]   node_mem [256];
  logic [63:0]         feat_mem [16];

  typedef struct {
    logic [CLASS_W-1:0] cls;
    logic               err;
    int                 exp_cyc;
  } exp_t;

  exp_t sb[$];

  int   assert_count = 0;
  int   fail_count   = 0;
  int   cyc          = 0;
  bit   stale_inject = 1'b0;
  bit   cmp_seen     = 1'b0;
  int   stab_viol    = 0;
  logic prev_en      = 1'b0;
  logic [63:0] prev_f = '0, prev_t = '0;

  localparam logic [63:0] THR_2P0   = 64'h00000002_00000000;
  localparam logic [63:0] THR_M0P5  = 64'hFFFFFFFF_80000000;
  localparam logic [63:0] F_1P5     = 64'h00000001_80000000;
  localparam logic [63:0] F_3P0     = 64'h00000003_00000000;
  localparam logic [63:0] F_M1P0    = 64'hFFFFFFFF_00000000;

  dt_tree_walker #(
    .NODE_AW(NODE_AW), .FEAT_AW(FEAT_AW), .CLASS_W(CLASS_W), .MAX_DEPTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .class_out(class_out), .err(err), .node_addr(node_addr),
    .node_rdata(node_rdata), .feat_addr(feat_addr), .feat_rdata(feat_rdata),
    .cmp_en(cmp_en), .cmp_feature(cmp_feature), .cmp_threshold(cmp_threshold),
    .cmp_go_left(cmp_go_left), .cmp_done(cmp_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous memories with one cycle of read latency.
  always @(posedge clk) begin
    node_rdata <= node_mem[node_addr];
    feat_rdata <= feat_mem[feat_addr];
  end

  // Registered comparator. With stale_inject set it also raises done with a
  // "go right" answer on the cycle after en was low, mimicking a stale done.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_done    <= 1'b0;
      cmp_go_left <= 1'b0;
    end else if (cmp_en) begin
      cmp_done    <= 1'b1;
      cmp_go_left <= ($signed(cmp_feature) <= $signed(cmp_threshold));
    end else begin
      cmp_done    <= stale_inject;
      cmp_go_left <= 1'b0;
    end
  end

  // Watches comparator operand stability while en is held.
  always @(posedge clk) begin
    if (cmp_en) cmp_seen <= 1'b1;
    if (cmp_en && prev_en && (cmp_feature !== prev_f || cmp_threshold !== prev_t))
      stab_viol <= stab_viol + 1;
    prev_en <= cmp_en;
    prev_f  <= cmp_feature;
    prev_t  <= cmp_threshold;
  end

  function automatic logic [NODE_W-1:0] mkNode(input bit leaf, input logic [3:0] fidx,
                                               input logic [7:0] l, input logic [7:0] r,
                                               input logic [63:0] thr);
    return {leaf, fidx, l, r, thr};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Root compares feature 2 against thr; left leaf class 3, right leaf class 7.
  task automatic loadTreeA(input logic [63:0] thr, input logic [63:0] f2);
    node_mem[0] = mkNode(1'b0, 4'd2, 8'd1, 8'd2, thr);
    node_mem[1] = mkNode(1'b1, 4'd0, 8'd0, 8'd0, 64'd3);
    node_mem[2] = mkNode(1'b1, 4'd0, 8'd0, 8'd0, 64'd7);
    feat_mem[2] = f2;
  endtask

  task automatic loadTreeDepth3();
    node_mem[0] = mkNode(1'b0, 4'd0, 8'd3, 8'd1, 64'd0);
    node_mem[1] = mkNode(1'b1, 4'd0, 8'd0, 8'd0, 64'd9);
    node_mem[3] = mkNode(1'b0, 4'd1, 8'd4, 8'd1, 64'd0);
    node_mem[4] = mkNode(1'b0, 4'd2, 8'd5, 8'd6, 64'd0);
    node_mem[5] = mkNode(1'b1, 4'd0, 8'd0, 8'd0, 64'd12);
    node_mem[6] = mkNode(1'b1, 4'd0, 8'd0, 8'd0, 64'd13);
    feat_mem[0] = F_M1P0;
    feat_mem[1] = 64'd0;
    feat_mem[2] = 64'd5 << 32;
  endtask

  // Pulses start for one cycle and records the expected outcome.
  task automatic applyStimulus(input logic [CLASS_W-1:0] cls, input logic e, input int lat);
    exp_t x;
    @(negedge clk);
    start = 1'b1;
    x.cls = cls; x.err = e; x.exp_cyc = cyc + 1 + lat;
    sb.push_back(x);
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_start", busy, 1);
  endtask

  // Waits (bounded) for done, then pops and compares the scoreboard entry.
  task automatic waitDone(input bit release_start);
    exp_t x;
    int n = 0;
    while (done !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (release_start) start = 1'b0;
    if (done !== 1'b1) begin
      checkOutput("done_timeout", 0, 1);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    if (sb.size() == 0) begin
      checkOutput("unexpected_done", 1, 0);
    end else begin
      x = sb.pop_front();
      checkOutput("class_out", class_out, x.cls);
      checkOutput("err", err, x.err);
      checkOutput("latency_cycle", cyc, x.exp_cyc);
    end
    @(negedge clk);
    checkOutput("done_one_cycle", done, 0);
    checkOutput("busy_after_done", busy, 0);
  endtask

  initial begin
    logic [63:0] f;
    logic [CLASS_W-1:0] exp_cls;
    int base, n, rises;
    bit extra;
    logic pe;

    for (int i = 0; i < 256; i++) node_mem[i] = '0;
    for (int i = 0; i < 16; i++) feat_mem[i] = '0;

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_cmp_en", cmp_en, 0);
    checkOutput("rst_class", class_out, 0);
    checkOutput("rst_node_addr", node_addr, 0);
    checkOutput("rst_feat_addr", feat_addr, 0);
    checkOutput("rst_cmp_feature", cmp_feature, 0);
    checkOutput("rst_cmp_threshold", cmp_threshold, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Root is a leaf
    node_mem[0] = mkNode(1'b1, 4'd0, 8'd0, 8'd0, 64'h5);
    cmp_seen = 1'b0;
    applyStimulus(4'd5, 1'b0, 2);
    waitDone(1'b0);
    checkOutput("leaf_no_cmp_en", cmp_seen, 0);

    // One internal level: less, greater, equal, negative
    loadTreeA(THR_2P0, F_1P5);
    applyStimulus(4'd3, 1'b0, 8);
    waitDone(1'b0);
    checkOutput("cmp_threshold_passthru", cmp_threshold, THR_2P0);
    checkOutput("cmp_feature_passthru", cmp_feature, F_1P5);
    loadTreeA(THR_2P0, F_3P0);
    applyStimulus(4'd7, 1'b0, 8);
    waitDone(1'b0);
    loadTreeA(THR_2P0, THR_2P0);
    applyStimulus(4'd3, 1'b0, 8);
    waitDone(1'b0);
    loadTreeA(THR_M0P5, F_M1P0);
    applyStimulus(4'd3, 1'b0, 8);
    waitDone(1'b0);

    // Stale done in the first compare cycle must be ignored
    loadTreeA(THR_2P0, F_1P5);
    stale_inject = 1'b1;
    applyStimulus(4'd3, 1'b0, 8);
    waitDone(1'b0);
    stale_inject = 1'b0;

    // Random features around the threshold, expected class from a signed compare
    for (int k = 0; k < 6; k++) begin
      f = {32'($urandom_range(0, 4)), 32'($urandom)};
      if ($urandom_range(0, 1) == 1) f = -f;
      exp_cls = ($signed(f) <= $signed(THR_2P0)) ? 4'd3 : 4'd7;
      loadTreeA(THR_2P0, f);
      applyStimulus(exp_cls, 1'b0, 8);
      waitDone(1'b0);
    end

    // Start held high: second walk begins one cycle after DONE
    loadTreeA(THR_2P0, F_3P0);
    @(negedge clk);
    start = 1'b1;
    base = cyc + 1;
    sb.push_back('{cls: 4'd7, err: 1'b0, exp_cyc: base + 8});
    sb.push_back('{cls: 4'd7, err: 1'b0, exp_cyc: base + 18});
    @(negedge clk);
    n = 0;
    while (done !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    x_check_first: begin
      exp_t x;
      if (done !== 1'b1) begin
        checkOutput("held_first_timeout", 0, 1);
        if (sb.size() > 0) void'(sb.pop_front());
      end else begin
        x = sb.pop_front();
        checkOutput("held_first_class", class_out, x.cls);
        checkOutput("held_first_cycle", cyc, x.exp_cyc);
      end
      @(negedge clk);
    end
    waitDone(1'b1);

    // Start while busy is ignored
    loadTreeA(THR_2P0, F_1P5);
    applyStimulus(4'd3, 1'b0, 8);
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(1'b0);
    extra = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) extra = 1'b1;
    end
    checkOutput("no_extra_done", extra, 0);

    // Self-loop terminates at the depth limit
    node_mem[0] = mkNode(1'b0, 4'd0, 8'd0, 8'd0, 64'd1);
    applyStimulus(4'd0, 1'b1, 2 + 6*16);
    waitDone(1'b0);

    // Reset during the third compare of a depth-3 walk
    loadTreeDepth3();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rises = 0; n = 0; pe = 1'b0;
    while (rises < 3 && n < 200) begin
      if (cmp_en === 1'b1 && pe !== 1'b1) rises++;
      pe = cmp_en;
      if (rises < 3) begin @(negedge clk); n++; end
    end
    checkOutput("reached_third_cmp", rises, 3);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_cmp_en", cmp_en, 0);
    checkOutput("midrst_done", done, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(4'd13, 1'b0, 20);
    waitDone(1'b0);

    checkOutput("operand_stable", stab_viol, 0);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
